// File: rtl/wb_arbiter_if.sv
// Bundle of the writeback arbiter's producer-side and regfile-side signals.
// The master side is whoever drives the ALU/B results; the slave side is the arbiter.
interface wb_arbiter_if #(
  parameter int DSIZE = 16,
  parameter int ASIZE = 4,
  parameter int DEPTH = 4
);
  logic                     a_valid;
  logic [ASIZE-1:0]         a_addr;
  logic [DSIZE-1:0]         a_data;
  logic                     stall_a;
  logic                     b_valid;
  logic                     b_ready;
  logic [ASIZE-1:0]         b_addr;
  logic [DSIZE-1:0]         b_data;
  logic                     wen;
  logic [ASIZE-1:0]         waddr;
  logic [DSIZE-1:0]         wdata;
  logic [$clog2(DEPTH):0]   fifo_count;

  modport master (
    output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    input  stall_a, b_ready, wen, waddr, wdata, fifo_count
  );

  modport slave (
    input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    output stall_a, b_ready, wen, waddr, wdata, fifo_count
  );
endinterface

// File: rtl/wb_arbiter.sv
// Regfile writeback arbiter: single-cycle ALU results have priority, long-latency
// results queue in a small FIFO, and a starvation counter briefly stalls the ALU.
module wb_arbiter #(
  parameter int DSIZE      = 16,
  parameter int ASIZE      = 4,
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 3
) (
  input logic         clk,
  input logic         rst,
  wb_arbiter_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

  logic [ASIZE-1:0] fifo_addr [DEPTH];
  logic [DSIZE-1:0] fifo_data [DEPTH];

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [SW-1:0]    starve_q, starve_d;
  logic             wen_q, wen_d;
  logic [ASIZE-1:0] waddr_q, waddr_d;
  logic [DSIZE-1:0] wdata_q, wdata_d;

  logic             stall, not_full, fifo_empty;
  logic             push, pop, grant_a, granted;
  logic [ASIZE-1:0] sel_addr;
  logic [DSIZE-1:0] sel_data;

  assign stall      = (starve_q == SMAX);
  assign not_full   = (count_q != FULL);
  assign fifo_empty = (count_q == '0);

  assign bus.stall_a    = stall;
  assign bus.b_ready    = not_full;
  assign bus.fifo_count = count_q;
  assign bus.wen        = wen_q;
  assign bus.waddr      = waddr_q;
  assign bus.wdata      = wdata_q;

  always_comb begin
    push     = bus.b_valid && not_full;
    grant_a  = bus.a_valid && !stall;
    pop      = !grant_a && !fifo_empty;
    granted  = grant_a || pop;
    sel_addr = grant_a ? bus.a_addr : fifo_addr[rd_ptr_q];
    sel_data = grant_a ? bus.a_data : fifo_data[rd_ptr_q];

    // r0 writes are consumed like any other but never reach the regfile
    wen_d   = granted && (sel_addr != '0);
    waddr_d = granted ? sel_addr : waddr_q;
    wdata_d = granted ? sel_data : wdata_q;

    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;

    count_d = count_q;
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (!push && pop) count_d = count_q - CW'(1);

    // A push into an empty FIFO holds the count; losing starts on the next cycle
    starve_d = starve_q;
    if (pop)                           starve_d = '0;
    else if (grant_a && !fifo_empty)   starve_d = stall ? SMAX : starve_q + SW'(1);
    else if (fifo_empty && !push)      starve_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      starve_q <= '0;
      wen_q    <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      starve_q <= starve_d;
      wen_q    <= wen_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
    end
  end

  // Storage is data only; stale entries are unreachable once the count is cleared
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr_q] <= bus.b_addr;
      fifo_data[wr_ptr_q] <= bus.b_data;
    end
  end
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed table-driven bench for wb_arbiter: each record is applied before an edge
// and the registered outputs are compared after it, plus a reset-while-busy sequence.
module tb_wb_arbiter;
  localparam int DSIZE = 16;
  localparam int ASIZE = 4;
  localparam int DEPTH = 4;
  localparam int SMAX  = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_arbiter_if #(.DSIZE(DSIZE), .ASIZE(ASIZE), .DEPTH(DEPTH)) bus ();

  wb_arbiter #(.DSIZE(DSIZE), .ASIZE(ASIZE), .DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        a_valid;
    logic [3:0]  a_addr;
    logic [15:0] a_data;
    logic        b_valid;
    logic [3:0]  b_addr;
    logic [15:0] b_data;
    logic        e_wen;
    logic [3:0]  e_waddr;
    logic [15:0] e_wdata;
    logic [2:0]  e_count;
    logic        e_rdy;
    logic        e_stall;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int errors = 0;

  function automatic vec_t mk(input logic av, input logic [3:0] aa, input logic [15:0] ad,
                              input logic bv, input logic [3:0] ba, input logic [15:0] bd,
                              input logic ew, input logic [3:0] ea, input logic [15:0] ed,
                              input logic [2:0] ec, input logic er, input logic es);
    vec_t v;
    v.a_valid = av; v.a_addr = aa; v.a_data = ad;
    v.b_valid = bv; v.b_addr = ba; v.b_data = bd;
    v.e_wen = ew; v.e_waddr = ea; v.e_wdata = ed;
    v.e_count = ec; v.e_rdy = er; v.e_stall = es;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag, input logic ew, input logic [3:0] ea,
                            input logic [15:0] ed, input logic [2:0] ec,
                            input logic er, input logic es);
    chk({tag, ".wen"},     32'(bus.wen),        32'(ew));
    chk({tag, ".waddr"},   32'(bus.waddr),      32'(ea));
    chk({tag, ".wdata"},   32'(bus.wdata),      32'(ed));
    chk({tag, ".count"},   32'(bus.fifo_count), 32'(ec));
    chk({tag, ".b_ready"}, 32'(bus.b_ready),    32'(er));
    chk({tag, ".stall_a"}, 32'(bus.stall_a),    32'(es));
  endtask

  task automatic drive(input logic av, input logic [3:0] aa, input logic [15:0] ad,
                       input logic bv, input logic [3:0] ba, input logic [15:0] bd);
    bus.a_valid = av; bus.a_addr = aa; bus.a_data = ad;
    bus.b_valid = bv; bus.b_addr = ba; bus.b_data = bd;
  endtask

  initial begin
    drive(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);

    // A-only, then idle holds address/data
    vecs.push_back(mk(1, 5, 16'h00AA, 0, 0, 0,        1, 5, 16'h00AA, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0,        0, 0, 0,        0, 5, 16'h00AA, 0, 1, 0));
    // Fill B to full under A traffic; the starvation guard fires as the FIFO fills
    vecs.push_back(mk(1, 9, 16'h0091, 1, 1, 16'd10,   1, 9, 16'h0091, 1, 1, 0));
    vecs.push_back(mk(1, 9, 16'h0092, 1, 2, 16'd20,   1, 9, 16'h0092, 2, 1, 0));
    vecs.push_back(mk(1, 9, 16'h0093, 1, 3, 16'd30,   1, 9, 16'h0093, 3, 1, 0));
    vecs.push_back(mk(1, 9, 16'h0094, 1, 4, 16'd40,   1, 9, 16'h0094, 4, 0, 1));
    vecs.push_back(mk(1, 9, 16'h0095, 1, 5, 16'd50,   1, 1, 16'd10,   3, 1, 0));
    vecs.push_back(mk(1, 9, 16'h0095, 0, 0, 0,        1, 9, 16'h0095, 3, 1, 0));
    // Drain in FIFO order
    vecs.push_back(mk(0, 0, 0,        0, 0, 0,        1, 2, 16'd20,   2, 1, 0));
    vecs.push_back(mk(0, 0, 0,        0, 0, 0,        1, 3, 16'd30,   1, 1, 0));
    vecs.push_back(mk(0, 0, 0,        0, 0, 0,        1, 4, 16'd40,   0, 1, 0));
    vecs.push_back(mk(0, 0, 0,        0, 0, 0,        0, 4, 16'd40,   0, 1, 0));
    // Starvation: one entry vs continuous A
    vecs.push_back(mk(0, 0, 0,        1, 7, 16'h1234, 0, 4, 16'd40,   1, 1, 0));
    vecs.push_back(mk(1, 6, 16'h0601, 0, 0, 0,        1, 6, 16'h0601, 1, 1, 0));
    vecs.push_back(mk(1, 6, 16'h0602, 0, 0, 0,        1, 6, 16'h0602, 1, 1, 0));
    vecs.push_back(mk(1, 6, 16'h0603, 0, 0, 0,        1, 6, 16'h0603, 1, 1, 1));
    vecs.push_back(mk(1, 6, 16'h0604, 0, 0, 0,        1, 7, 16'h1234, 0, 1, 0));
    vecs.push_back(mk(1, 6, 16'h0604, 0, 0, 0,        1, 6, 16'h0604, 0, 1, 0));
    // r0 suppression on both sources
    vecs.push_back(mk(1, 0, 16'hFFFF, 0, 0, 0,        0, 0, 16'hFFFF, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0,        1, 0, 16'hBEEF, 0, 0, 16'hFFFF, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0,        0, 0, 0,        0, 0, 16'hBEEF, 0, 1, 0));
    // Simultaneous push/pop at count 2
    vecs.push_back(mk(1, 8, 16'h0801, 1, 10, 16'h00A0, 1, 8, 16'h0801, 1, 1, 0));
    vecs.push_back(mk(1, 8, 16'h0802, 1, 11, 16'h00B0, 1, 8, 16'h0802, 2, 1, 0));
    vecs.push_back(mk(0, 0, 0,        1, 12, 16'h00C0, 1, 10, 16'h00A0, 2, 1, 0));
    vecs.push_back(mk(0, 0, 0,        1, 13, 16'h00D0, 1, 11, 16'h00B0, 2, 1, 0));
    vecs.push_back(mk(0, 0, 0,        0, 0, 0,         1, 12, 16'h00C0, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0,        0, 0, 0,         1, 13, 16'h00D0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0,        0, 0, 0,         0, 13, 16'h00D0, 0, 1, 0));
    // Queue three entries with writes active, ahead of the reset sequence
    vecs.push_back(mk(1, 3, 16'h0301, 1, 1, 16'h0011, 1, 3, 16'h0301, 1, 1, 0));
    vecs.push_back(mk(1, 3, 16'h0302, 1, 2, 16'h0022, 1, 3, 16'h0302, 2, 1, 0));
    vecs.push_back(mk(1, 3, 16'h0303, 1, 3, 16'h0033, 1, 3, 16'h0303, 3, 1, 0));

    repeat (2) @(negedge clk);
    check_outs("reset", 1'b0, 4'd0, 16'h0, 3'd0, 1'b1, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].a_valid, vecs[i].a_addr, vecs[i].a_data,
            vecs[i].b_valid, vecs[i].b_addr, vecs[i].b_data);
      @(negedge clk);
      check_outs($sformatf("vec%0d", i), vecs[i].e_wen, vecs[i].e_waddr, vecs[i].e_wdata,
                 vecs[i].e_count, vecs[i].e_rdy, vecs[i].e_stall);
    end

    // Asynchronous reset mid-operation clears outputs without waiting for an edge
    drive(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);
    rst = 1'b1;
    #1;
    check_outs("rst_async", 1'b0, 4'd0, 16'h0, 3'd0, 1'b1, 1'b0);
    @(negedge clk);
    check_outs("rst_held", 1'b0, 4'd0, 16'h0, 3'd0, 1'b1, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_outs($sformatf("post_rst%0d", i), 1'b0, 4'd0, 16'h0, 3'd0, 1'b1, 1'b0);
    end

    // Fresh traffic after reset uses the cleared FIFO from its new head
    drive(1'b0, 4'd0, 16'h0, 1'b1, 4'd14, 16'h0E0E);
    @(negedge clk);
    check_outs("new_push", 1'b0, 4'd0, 16'h0, 3'd1, 1'b1, 1'b0);
    drive(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);
    @(negedge clk);
    check_outs("new_pop", 1'b1, 4'd14, 16'h0E0E, 3'd0, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
